// File: rtl/handshake_tx_fifo.sv
// rtl/handshake_tx_fifo.sv - FIFO-fed transmit side of a four-phase rdy/ack handshake
//
// Words are queued in a DEPTH-entry FIFO and sent one at a time on o_t_rdy/o_t_data.
// The asynchronous receiver ack is synchronised through SYNC_STAGES flops (ack_s).
// Optional macro HANDSHAKE_TX_TIMEOUT_EN adds an ack timeout that aborts a stalled word.
//
// Ports:
//   i_tclk        clock
//   i_trst        synchronous active-high reset
//   i_t_data      word to queue
//   i_data_avail  push strobe, accepted when o_full=0
//   o_full        FIFO full, pushes ignored
//   o_level       FIFO occupancy, excluding the word in flight
//   i_r_ack       receiver ack, asynchronous to i_tclk
//   o_t_data      word on the handshake bus (0 when o_t_rdy=0)
//   o_t_rdy       registered request
//   o_busy        FSM not IDLE or FIFO not empty
//   o_timeout     one-cycle abort pulse (constant 0 without HANDSHAKE_TX_TIMEOUT_EN)

module handshake_tx_fifo #(
  parameter int DW          = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         i_tclk,
  input  logic                         i_trst,
  input  logic [DW-1:0]                i_t_data,
  input  logic                         i_data_avail,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  input  logic                         i_r_ack,
  output logic [DW-1:0]                o_t_data,
  output logic                         o_t_rdy,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  if (DW < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2 || TIMEOUT_CYC < 2)
  begin : g_param_check
    $error("handshake_tx_fifo: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_ASSERT        = 2'd1,
    ST_WAIT_DEASSERT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_next;

  logic push, pop, load, clr, rdy_next;

`ifdef HANDSHAKE_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC+1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] to_cnt;
  logic          to_fire;
`endif

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // o_full is the registered flag, so a full FIFO refuses a push even while it pops.
  assign push = i_data_avail && !o_full;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    clr        = 1'b0;
    rdy_next   = o_t_rdy;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
    to_fire    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        rdy_next = 1'b0;
        // A stale ack from the previous handshake must drain before a new request.
        if (o_level != '0 && !ack_s) begin
          pop        = 1'b1;
          load       = 1'b1;
          rdy_next   = 1'b1;
          state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        rdy_next = 1'b1;
        if (ack_s) begin
          rdy_next   = 1'b0;
          clr        = 1'b1;
          state_next = ST_WAIT_DEASSERT;
        end
`ifdef HANDSHAKE_TX_TIMEOUT_EN
        // Ack takes priority over expiry in the same cycle.
        else if (to_cnt == TO_LAST) begin
          rdy_next   = 1'b0;
          clr        = 1'b1;
          to_fire    = 1'b1;
          state_next = ST_WAIT_DEASSERT;
        end
`endif
      end
      ST_WAIT_DEASSERT: begin
        rdy_next = 1'b0;
        if (!ack_s) begin
          if (o_level != '0) begin
            pop        = 1'b1;
            load       = 1'b1;
            rdy_next   = 1'b1;
            state_next = ST_ASSERT;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        rdy_next   = 1'b0;
        clr        = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    level_next = o_level;
    case ({push, pop})
      2'b10:   level_next = o_level + LW'(1);
      2'b01:   level_next = o_level - LW'(1);
      default: level_next = o_level;
    endcase
  end

  always_ff @(posedge i_tclk) begin
    if (i_trst) begin
      ack_sync  <= '0;
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_level   <= '0;
      o_full    <= 1'b0;
      o_busy    <= 1'b0;
      o_t_rdy   <= 1'b0;
      o_t_data  <= '0;
      o_timeout <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], i_r_ack};
      state    <= state_next;
      if (push) begin
        mem[wr_ptr] <= i_t_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      o_level <= level_next;
      o_full  <= (level_next == LEVEL_FULL);
      o_busy  <= (state_next != ST_IDLE) || (level_next != '0);
      o_t_rdy <= rdy_next;
      if (load) begin
        o_t_data <= mem[rd_ptr];
      end else if (clr) begin
        o_t_data <= '0;
      end
`ifdef HANDSHAKE_TX_TIMEOUT_EN
      o_timeout <= to_fire;
`else
      o_timeout <= 1'b0;
`endif
    end
  end

`ifdef HANDSHAKE_TX_TIMEOUT_EN
  always_ff @(posedge i_tclk) begin
    if (i_trst) begin
      to_cnt <= '0;
    end else if (state_next == ST_ASSERT && state != ST_ASSERT) begin
      to_cnt <= '0;
    end else if (state == ST_ASSERT && !ack_s) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_handshake_tx_fifo.sv
// tb/tb_handshake_tx_fifo.sv - scoreboard bench for handshake_tx_fifo

module tb_handshake_tx_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int SS = 2;
  localparam int TO = 8;
  localparam int LW = $clog2(DEPTH+1);

  logic          i_tclk = 1'b0;
  logic          i_trst;
  logic [DW-1:0] i_t_data;
  logic          i_data_avail;
  logic          o_full;
  logic [LW-1:0] o_level;
  logic          i_r_ack;
  logic [DW-1:0] o_t_data;
  logic          o_t_rdy;
  logic          o_busy;
  logic          o_timeout;

  always #5 i_tclk = ~i_tclk;

  handshake_tx_fifo #(
    .DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)
  ) dut (
    .i_tclk(i_tclk), .i_trst(i_trst), .i_t_data(i_t_data), .i_data_avail(i_data_avail),
    .o_full(o_full), .o_level(o_level), .i_r_ack(i_r_ack), .o_t_data(o_t_data),
    .o_t_rdy(o_t_rdy), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  int            errors = 0;
  int            checks = 0;
  int            to_pulses = 0;
  logic [DW-1:0] exp_q [$];
  logic          idle_seen;
  logic          flag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_tclk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w, input logic acc);
    i_data_avail = 1'b1;
    i_t_data     = w;
    if (acc) exp_q.push_back(w);
    step();
    i_data_avail = 1'b0;
    i_t_data     = '0;
  endtask

  task automatic wait_rdy(input logic lvl, input string name);
    int n = 0;
    while (o_t_rdy !== lvl && n < 20) begin
      step();
      n++;
    end
    check(name, o_t_rdy, lvl);
  endtask

  // Completes the current handshake; optionally pushes in the cycle where the next word pops.
  task automatic ack_cycle(input logic do_push, input logic [DW-1:0] w, input logic acc);
    i_r_ack = 1'b1;
    wait_rdy(1'b0, "ack_drop");
    i_r_ack = 1'b0;
    step();
    if (!o_busy) idle_seen = 1'b1;
    step();
    if (!o_busy) idle_seen = 1'b1;
    if (do_push) begin
      i_data_avail = 1'b1;
      i_t_data     = w;
      if (acc) exp_q.push_back(w);
    end
    step();
    i_data_avail = 1'b0;
    i_t_data     = '0;
  endtask

  task automatic finish_word();
    i_r_ack = 1'b1;
    wait_rdy(1'b0, "final_ack_drop");
    i_r_ack = 1'b0;
    repeat (3) step();
  endtask

  // Monitor: every rising o_t_rdy must present the next expected word, held stable while high.
  initial begin : monitor
    logic          prev_rdy;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp;
    prev_rdy  = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge i_tclk);
      if (o_timeout === 1'b1) to_pulses++;
      if (o_t_rdy === 1'b1 && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_order: unexpected word 0x%0h with nothing queued", o_t_data);
        end else begin
          exp = exp_q.pop_front();
          check("word_order", o_t_data, exp);
        end
      end else if (o_t_rdy === 1'b1 && prev_rdy) begin
        check("data_stable", o_t_data, prev_data);
      end
      prev_rdy  = (o_t_rdy === 1'b1);
      prev_data = o_t_data;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    i_trst       = 1'b1;
    i_t_data     = '0;
    i_data_avail = 1'b0;
    i_r_ack      = 1'b0;
    idle_seen    = 1'b0;
    repeat (3) step();
    check("rst_rdy", o_t_rdy, 0);
    check("rst_data", o_t_data, 0);
    check("rst_full", o_full, 0);
    check("rst_level", o_level, 0);
    check("rst_busy", o_busy, 0);
    check("rst_timeout", o_timeout, 0);
    i_trst = 1'b0;
    step();

    // Single word: latency, sync delay on ack, return to idle.
    push(32'hA5A5_0001, 1'b1);
    check("t1_level_n1", o_level, 1);
    check("t1_rdy_n1", o_t_rdy, 0);
    step();
    check("t1_rdy_n2", o_t_rdy, 1);
    check("t1_data_n2", o_t_data, 32'hA5A5_0001);
    check("t1_level_n2", o_level, 0);
    i_r_ack = 1'b1;
    step();
    step();
    check("t1_rdy_before_sync", o_t_rdy, 1);
    step();
    check("t1_rdy_after_sync", o_t_rdy, 0);
    check("t1_data_cleared", o_t_data, 0);
    i_r_ack = 1'b0;
    repeat (3) step();
    check("t1_busy_idle", o_busy, 0);

    // Burst: 1 in flight, 2..5 queued, 6 dropped.
    push(32'd1, 1'b1);
    push(32'd2, 1'b1);
    push(32'd3, 1'b1);
    push(32'd4, 1'b1);
    push(32'd5, 1'b1);
    push(32'd6, 1'b0);
    check("t2_full", o_full, 1);
    check("t2_level", o_level, 4);
    check("t2_data", o_t_data, 32'd1);
    ack_cycle(1'b1, 32'd7, 1'b0);
    check("t3_full_push_rejected_level", o_level, 3);
    check("t3_full_cleared", o_full, 0);
    check("t2_chain_rdy_w2", o_t_rdy, 1);
    ack_cycle(1'b0, '0, 1'b0);
    check("t2_level_after_w3", o_level, 2);
    ack_cycle(1'b1, 32'd8, 1'b1);
    check("t3_push_pop_level", o_level, 2);
    check("t2_chain_data_w4", o_t_data, 32'd4);
    ack_cycle(1'b0, '0, 1'b0);
    check("t2_chain_data_w5", o_t_data, 32'd5);
    ack_cycle(1'b0, '0, 1'b0);
    check("t2_chain_data_w8", o_t_data, 32'd8);
    check("t2_no_idle_between", idle_seen, 0);
    finish_word();
    check("t2_busy_end", o_busy, 0);
    check("t2_queue_drained", exp_q.size(), 0);

    // Reset during ASSERT with three words queued.
    push(32'd9, 1'b1);
    push(32'd10, 1'b1);
    push(32'd11, 1'b1);
    push(32'd12, 1'b1);
    check("t4_pre_level", o_level, 3);
    check("t4_pre_rdy", o_t_rdy, 1);
    i_trst = 1'b1;
    step();
    i_trst = 1'b0;
    exp_q.delete();
    check("t4_rdy", o_t_rdy, 0);
    check("t4_data", o_t_data, 0);
    check("t4_level", o_level, 0);
    check("t4_full", o_full, 0);
    flag    = 1'b0;
    i_r_ack = 1'b1;
    repeat (4) begin
      step();
      if (o_t_rdy) flag = 1'b1;
    end
    check("t4_busy_ack_ignored", o_busy, 0);

    // Ack still high when a word arrives: request waits for ack_s=0.
    push(32'd13, 1'b1);
    repeat (4) begin
      step();
      if (o_t_rdy) flag = 1'b1;
    end
    check("t5_no_rdy_while_ack", flag, 0);
    check("t5_level_held", o_level, 1);
    i_r_ack = 1'b0;
    step();
    step();
    check("t5_rdy_still_low", o_t_rdy, 0);
    step();
    check("t5_rdy_rise", o_t_rdy, 1);
    check("t5_data", o_t_data, 32'd13);
    finish_word();
    check("t5_busy_end", o_busy, 0);

`ifdef HANDSHAKE_TX_TIMEOUT_EN
    // Timeout: 8 cycles high, abort pulse, next word one cycle later; then ack on expiry.
    push(32'd20, 1'b1);
    push(32'd21, 1'b1);
    flag = 1'b1;
    repeat (7) begin
      step();
      if (!o_t_rdy) flag = 1'b0;
    end
    check("t6_rdy_held_8", flag, 1);
    step();
    check("t6_abort_rdy", o_t_rdy, 0);
    check("t6_abort_pulse", o_timeout, 1);
    check("t6_abort_data", o_t_data, 0);
    step();
    check("t6_pulse_one_cycle", o_timeout, 0);
    check("t6_next_rdy", o_t_rdy, 1);
    check("t6_next_data", o_t_data, 32'd21);
    repeat (5) step();
    i_r_ack = 1'b1;
    step();
    step();
    check("t6_rdy_before_expiry", o_t_rdy, 1);
    step();
    check("t6_ack_wins_rdy", o_t_rdy, 0);
    check("t6_ack_wins_no_timeout", o_timeout, 0);
    i_r_ack = 1'b0;
    repeat (3) step();
    check("t6_busy_end", o_busy, 0);
    check("timeout_pulse_count", to_pulses, 1);
`else
    check("timeout_pulse_count", to_pulses, 0);
`endif
    check("queue_drained_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
